// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher
// Stretches single-cycle event pulses into human-visible LED flashes. Each
// accepted event shows ON_TICKS slow ticks of led_out high, followed by a
// mandatory OFF_TICKS low gap. A slow tick happens once per TICK_LIMIT+1
// clk cycles.
//
// Build option: define LED_PULSE_QUEUE_EN to let events that arrive while a
// flash is in progress wait in a counting queue of up to QUEUE_DEPTH entries.
// Without the macro there is no queue: pending is tied to 0, and such events
// are dropped with an overflow pulse.
//
// Reset is asynchronous and active-high. It discards the current event and
// every queued event.
module led_pulse_stretcher #(
    parameter int TICK_LIMIT  = 10,
    parameter int ON_TICKS    = 4,
    parameter int OFF_TICKS   = 4,
    parameter int QUEUE_DEPTH = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pulse_in,
    output logic       led_out,
    output logic       busy,
    output logic [3:0] pending,
    output logic       overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [26:0] TICK_TERM = 27'(TICK_LIMIT);
    localparam logic [7:0]  ON_LAST   = 8'(ON_TICKS - 1);
    localparam logic [7:0]  OFF_LAST  = 8'(OFF_TICKS - 1);

    // Catch illegal parameter values at elaboration time.
    if (ON_TICKS < 1 || ON_TICKS > 255) begin : g_bad_on_ticks
        $error("led_pulse_stretcher: ON_TICKS must be 1..255");
    end
    if (OFF_TICKS < 1 || OFF_TICKS > 255) begin : g_bad_off_ticks
        $error("led_pulse_stretcher: OFF_TICKS must be 1..255");
    end
    if (QUEUE_DEPTH < 1 || QUEUE_DEPTH > 15) begin : g_bad_depth
        $error("led_pulse_stretcher: QUEUE_DEPTH must be 1..15");
    end
    if (TICK_LIMIT < 0 || TICK_LIMIT > 134217727) begin : g_bad_tick
        $error("led_pulse_stretcher: TICK_LIMIT must fit in 27 bits");
    end

    state_t      state_reg;
    state_t      state_next;
    logic [26:0] presc_reg;
    logic [26:0] presc_next;
    logic [7:0]  phase_reg;
    logic [7:0]  phase_next;
    logic        led_reg;
    logic        overflow_reg;
    logic        drop;

    logic        tick;
    logic        on_done;
    logic        gap_done;
    logic        has_pending;
    logic        dequeue;

    assign tick     = (presc_reg == TICK_TERM);
    assign on_done  = (state_reg == ST_ON)  && tick && (phase_reg == ON_LAST);
    assign gap_done = (state_reg == ST_GAP) && tick && (phase_reg == OFF_LAST);

`ifdef LED_PULSE_QUEUE_EN
    localparam logic [3:0] DEPTH = 4'(QUEUE_DEPTH);

    logic [3:0] pending_reg;
    logic [3:0] pending_next;
    logic       enqueue;

    assign has_pending = (pending_reg != 4'd0);
    // A queued event takes priority at the end of a gap.
    assign dequeue     = gap_done && has_pending;
    // A pulse on the gap-end cycle with an empty queue starts the next flash
    // directly, so only the other busy-time pulses go into the queue.
    assign enqueue     = pulse_in && (state_reg != ST_IDLE) &&
                         !(gap_done && !has_pending);

    // Queue occupancy: saturating up/down counter; enqueue and dequeue in
    // the same cycle cancel, even when the queue is full.
    always_comb begin
        pending_next = pending_reg;
        drop         = 1'b0;
        if (enqueue && dequeue) begin
            pending_next = pending_reg;
        end else if (enqueue) begin
            if (pending_reg < DEPTH) begin
                pending_next = pending_reg + 4'd1;
            end else begin
                drop = 1'b1;
            end
        end else if (dequeue) begin
            pending_next = pending_reg - 4'd1;
        end
    end

    // Queue occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= 4'd0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign pending = pending_reg;
`else
    assign has_pending = 1'b0;
    assign dequeue     = 1'b0;
    assign pending     = 4'd0;

    // No storage: any busy-time pulse that cannot start a flash is lost.
    always_comb begin
        drop = pulse_in && (state_reg != ST_IDLE) && !gap_done;
    end
`endif

    // Next-state logic for the IDLE / ON / GAP sequencer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pulse_in) begin
                    state_next = ST_ON;
                end
            end
            ST_ON: begin
                if (on_done) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    if (dequeue || pulse_in) begin
                        state_next = ST_ON;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Prescaler and phase counter. The prescaler idles at zero and wraps at
    // its terminal count. The phase counter restarts on each state change,
    // so every flash and every gap starts from a clean count.
    always_comb begin
        presc_next = presc_reg;
        phase_next = phase_reg;
        if (state_reg == ST_IDLE || tick) begin
            presc_next = 27'd0;
        end else begin
            presc_next = presc_reg + 27'd1;
        end
        if (state_next != state_reg) begin
            phase_next = 8'd0;
        end else if (tick) begin
            phase_next = phase_reg + 8'd1;
        end
    end

    // State, timing counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            presc_reg    <= 27'd0;
            phase_reg    <= 8'd0;
            led_reg      <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            presc_reg    <= presc_next;
            phase_reg    <= phase_next;
            led_reg      <= (state_next == ST_ON);
            overflow_reg <= drop;
        end
    end

    assign led_out  = led_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign overflow = overflow_reg;

endmodule

// File: doc/led_pulse_stretcher.md
LED_PULSE_STRETCHER -- requirements
Module: led_pulse_stretcher

Interface
REQ-001 Parameter TICK_LIMIT, default 10: prescaler terminal count; one slow tick per TICK_LIMIT+1 clk cycles.
REQ-002 Parameter ON_TICKS, default 4: slow ticks led_out is held high per event (legal 1..255).
REQ-003 Parameter OFF_TICKS, default 4: slow ticks of enforced low gap after each event (legal 1..255).
REQ-004 Parameter QUEUE_DEPTH, default 15: maximum pending events held (legal 1..15).
REQ-005 Clocking: one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  system clock; all state on its rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 pulse_in  input  1  single-cycle event request, e.g. a debounced button pulse; sampled every clk.
REQ-009 led_out  output  1  registered human-visible stretched output.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 pending  output  4  number of queued events not yet displayed.
REQ-012 overflow  output  1  one-cycle pulse when a pulse_in is dropped.

Function
REQ-013 FSM states: IDLE, ON, GAP; led_out = 1 exactly when state is ON, registered.
REQ-014 Prescaler: 27-bit counter held at 0 in IDLE, counts 0..TICK_LIMIT then wraps to 0 in ON/GAP; tick = (counter == TICK_LIMIT).
REQ-015 Phase counter: 8-bit, cleared on every state entry, increments on tick.
REQ-016 IDLE -> ON on the edge where pulse_in = 1; led_out high the following cycle (latency 1 cycle); pending unchanged.
REQ-017 ON -> GAP on tick with phase count = ON_TICKS-1; ON lasts exactly ON_TICKS*(TICK_LIMIT+1) cycles.
REQ-018 GAP end = tick with phase count = OFF_TICKS-1; GAP lasts exactly OFF_TICKS*(TICK_LIMIT+1) cycles.
REQ-019 At GAP end: pending > 0 -> ON, pending decremented; else pulse_in = 1 on that cycle -> ON, pulse consumed directly; else -> IDLE.
REQ-020 pulse_in while busy and not consumed per REQ-019: pending increments if pending < QUEUE_DEPTH, else pulse dropped and overflow = 1 next cycle.
REQ-021 Simultaneous enqueue and dequeue (pulse_in at GAP end with pending > 0): pending unchanged, no overflow.
REQ-022 pending never wraps; it saturates at QUEUE_DEPTH and never goes below 0.
REQ-023 Every accepted pulse_in yields exactly one ON phase; events are never merged.

Reset
REQ-024 rst = 1 asynchronously forces state IDLE, prescaler 0, phase 0, led_out 0, busy 0, pending 0, overflow 0.
REQ-025 Reset asserted mid-ON or mid-GAP discards the current event and all pending events; no partial phase resumes.
REQ-026 First pulse_in accepted is one sampled on the first clk edge with rst low.

Configuration
REQ-027 Macro LED_PULSE_QUEUE_EN defined: queueing per REQ-019..REQ-022 is active.
REQ-028 Macro LED_PULSE_QUEUE_EN undefined: no queue storage; pending tied to 0; every pulse_in while busy and not consumed at GAP end is dropped with overflow = 1 next cycle; REQ-016..REQ-018 unchanged.

Verification (defaults: ON 44 cycles, GAP 44 cycles)
REQ-029 Reset, then one pulse_in at cycle 0 -> led_out high on cycles 1..44, low on cycles 45..88, busy low from cycle 89, pending 0 throughout.
REQ-030 With queue enabled, 3 pulses at cycles 0, 5 and 10 -> pending goes 1 then 2; led_out shows 3 separate 44-cycle highs separated by 44-cycle lows; pending returns to 0.
REQ-031 With queue enabled, 17 pulses while busy -> pending saturates at 15; overflow pulses exactly twice; 16 ON phases total are displayed.
REQ-032 pulse_in exactly on the GAP-end cycle, with pending 0 and with pending 2 -> ON re-entered the next cycle in both cases; pending stays 0 and stays 2 respectively.
REQ-033 rst asserted mid-ON with pending 3 -> led_out, busy and pending go 0 asynchronously; a pulse_in after release restarts the REQ-029 timing.
REQ-034 With macro undefined, pulse at cycle 0 and pulse at cycle 20 -> single 44-cycle high, overflow high on cycle 21, pending always 0.
